// File: rtl/mmio_uart_pkg.sv
// Shared types and constants for the display-MMIO UART transmitter.
// The state encodings are fixed constants so that legacy tools can match them.
package mmio_uart_pkg;

    localparam logic [19:0] DISP_PAGE    = 20'hAAAAA;
    localparam logic [11:0] DISP_WEA_OFF = 12'h004;
    localparam logic [11:0] DISP_DAT_OFF = 12'h008;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP
    } tx_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// Synchronous first-word-fall-through word FIFO; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module uart_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               dout,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (level_r == LW'(DEPTH));
    assign empty     = (level_r == {LW{1'b0}});
    assign push_ok_s = push & (~full | pop);
    assign pop_ok_s  = pop & ~empty;
    assign dout      = mem_r[rd_ptr_r];
    assign level     = level_r;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LW'(1'b1);
                2'b01:   level_r <= level_r - LW'(1'b1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/mmio_disp_uart_tx.sv
// Display MMIO consumer: each rising edge of disp_wea queues disp_dat, and an
// 8N1 transmitter sends every queued word LS byte first.
module mmio_disp_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               disp_wea,
    input  logic [31:0]                        disp_dat,
    input  logic                               ovf_clr,
    output logic                               tx,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               overflow
);

    localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int BW  = $clog2(CPB);
    localparam int LW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);

    logic            wea_q_r;
    logic            push_s;
    logic            push_ok_s;
    logic            pop_s;
    logic            ovf_set_s;
    logic            full_s;
    logic            empty_s;
    logic [31:0]     fifo_dout_s;
    logic [LW-1:0]   fifo_level_s;
    logic [LW-1:0]   level_nx_s;

    tx_state_t       state_r;
    tx_state_t       state_nx_s;
    logic [BW-1:0]   baud_r;
    logic [BW-1:0]   baud_nx_s;
    logic            baud_wrap_s;
    logic [2:0]      bit_r;
    logic [2:0]      bit_nx_s;
    logic [1:0]      byte_r;
    logic [1:0]      byte_nx_s;
    logic [31:0]     shift_r;
    logic [31:0]     shift_nx_s;
    logic            tx_nx_s;
    logic            tx_r;
    logic            busy_r;
    logic            overflow_r;

    assign push_s      = disp_wea & ~wea_q_r;
    assign push_ok_s   = push_s & (~full_s | pop_s);
    assign ovf_set_s   = push_s & full_s & ~pop_s;
    assign baud_wrap_s = (baud_r == BAUD_LAST);
    assign level_nx_s  = fifo_level_s + LW'(push_ok_s) - LW'(pop_s);

    uart_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (disp_dat),
        .dout  (fifo_dout_s),
        .full  (full_s),
        .empty (empty_s),
        .level (fifo_level_s)
    );

    // Next-state logic: bit and byte only advance on the baud wrap cycle.
    always_comb begin
        state_nx_s = state_r;
        baud_nx_s  = baud_r;
        bit_nx_s   = bit_r;
        byte_nx_s  = byte_r;
        shift_nx_s = shift_r;
        pop_s      = 1'b0;
        case (state_r)
            IDLE: begin
                baud_nx_s = {BW{1'b0}};
                if (!empty_s) begin
                    pop_s      = 1'b1;
                    shift_nx_s = fifo_dout_s;
                    byte_nx_s  = 2'd0;
                    bit_nx_s   = 3'd0;
                    state_nx_s = START;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            START: begin
                if (baud_wrap_s) begin
                    baud_nx_s  = {BW{1'b0}};
                    bit_nx_s   = 3'd0;
                    state_nx_s = DATA;
                end else begin
                    baud_nx_s = baud_r + BW'(1'b1);
                end
            end
            DATA: begin
                if (baud_wrap_s) begin
                    baud_nx_s = {BW{1'b0}};
                    if (bit_r == 3'd7) begin
                        state_nx_s = STOP;
                    end else begin
                        bit_nx_s = bit_r + 3'd1;
                    end
                end else begin
                    baud_nx_s = baud_r + BW'(1'b1);
                end
            end
            STOP: begin
                if (baud_wrap_s) begin
                    baud_nx_s = {BW{1'b0}};
                    if (byte_r != 2'd3) begin
                        byte_nx_s  = byte_r + 2'd1;
                        state_nx_s = START;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end else begin
                    baud_nx_s = baud_r + BW'(1'b1);
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Line level follows the next state so the flopped tx lines up with state_r.
    always_comb begin
        tx_nx_s = 1'b1;
        case (state_nx_s)
            START:   tx_nx_s = 1'b0;
            DATA:    tx_nx_s = shift_nx_s[{byte_nx_s, bit_nx_s}];
            default: tx_nx_s = 1'b1;
        endcase
    end

    // State, counters, line and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wea_q_r    <= 1'b0;
            state_r    <= IDLE;
            baud_r     <= {BW{1'b0}};
            bit_r      <= 3'd0;
            byte_r     <= 2'd0;
            shift_r    <= 32'h0000_0000;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            wea_q_r <= disp_wea;
            state_r <= state_nx_s;
            baud_r  <= baud_nx_s;
            bit_r   <= bit_nx_s;
            byte_r  <= byte_nx_s;
            shift_r <= shift_nx_s;
            tx_r    <= tx_nx_s;
            busy_r  <= (state_nx_s != IDLE) | (level_nx_s != {LW{1'b0}});
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign tx         = tx_r;
    assign busy       = busy_r;
    assign fifo_level = fifo_level_s;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_mmio_disp_uart_tx.sv
// Directed scenarios plus random words, checked against a word-level timing
// model and a UART line decoder.
module tb_mmio_disp_uart_tx;

    localparam int CPB   = 10;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;
    localparam int WORD  = 4 * FRAME;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        disp_wea = 1'b0;
    logic [31:0] disp_dat = 32'h0;
    logic        ovf_clr = 1'b0;
    logic        tx;
    logic        busy;
    logic [2:0]  fifo_level;
    logic        overflow;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Model state: push cycles of queued words, first cycle the line is free.
    int         mq[$];
    int         free_cyc = 0;
    bit         m_ovf = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         start_q[$];

    bit         mon_active = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_acc = 8'h00;

    mmio_disp_uart_tx #(
        .CLK_HZ     (1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .disp_wea   (disp_wea),
        .disp_dat   (disp_dat),
        .ovf_clr    (ovf_clr),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line decoder: samples mid-bit, relative to the first low cycle.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt = 0;
                start_q.push_back(cyc);
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % CPB == CPB / 2) begin
                if (mon_cnt / CPB == 0) begin
                    chk("start_bit", tx, 1'b0);
                end else if (mon_cnt / CPB <= 8) begin
                    mon_acc[mon_cnt / CPB - 1] = tx;
                end else begin
                    chk("stop_bit", tx, 1'b1);
                    rx_q.push_back(mon_acc);
                end
            end
            if (mon_cnt == FRAME - 1) mon_active = 1'b0;
        end
    end

    // Word-level model: retire words whose pop cycle has come, then accept or drop.
    task automatic model_edge(input int e, input logic [31:0] d, input bit clr);
        int p;
        while (mq.size() > 0) begin
            p = (mq[0] + 1 > free_cyc) ? mq[0] + 1 : free_cyc;
            if (p <= e) begin
                void'(mq.pop_front());
                free_cyc = p + WORD + 1;
            end else begin
                break;
            end
        end
        if (mq.size() < DEPTH) begin
            mq.push_back(e);
            for (int b = 0; b < 4; b++) exp_q.push_back(d[8*b +: 8]);
            if (clr) m_ovf = 1'b0;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic do_edge(input logic [31:0] d, input bit clr, output int e);
        @(negedge clk);
        disp_wea = 1'b1;
        disp_dat = d;
        ovf_clr  = clr;
        e = cyc;
        model_edge(e, d, clr);
        @(negedge clk);
        disp_wea = 1'b0;
        ovf_clr  = 1'b0;
        disp_dat = $urandom;
        chk("edge_level", fifo_level, mq.size());
        chk("edge_ovf", overflow, m_ovf);
    endtask

    task automatic wait_start(output int s);
        int n = 0;
        while (start_q.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", start_q.size() > 0, 1'b1);
        s = (start_q.size() > 0) ? start_q[0] : 0;
    endtask

    task automatic check_rx(input string tag);
        int n = 0;
        int m;
        while ((busy !== 1'b0 || mon_active) && n < 30000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle_timeout"}, n < 30000, 1'b1);
        repeat (3) @(negedge clk);
        chk({tag, "_rx_count"}, rx_q.size(), exp_q.size());
        m = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
        start_q.delete();
    endtask

    initial begin
        int e;
        int s;
        int n;
        logic [31:0] d;

        repeat (5) begin
            @(negedge clk);
            chk("rst_tx", tx, 1'b1);
            chk("rst_busy", busy, 1'b0);
            chk("rst_level", fifo_level, 3'd0);
            chk("rst_ovf", overflow, 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Single word: latency, busy window, byte order.
        do_edge(32'h44434241, 1'b0, e);
        chk("t2_busy_up", busy, 1'b1);
        wait_start(s);
        chk("t2_latency", s - e, 2);
        n = 0;
        while (busy !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("t2_busy_drop", cyc - s, WORD);
        check_rx("t2");

        // Level held high with changing data: one word, edge-cycle data.
        @(negedge clk);
        d = $urandom;
        disp_wea = 1'b1;
        disp_dat = d;
        model_edge(cyc, d, 1'b0);
        repeat (49) begin
            @(negedge clk);
            disp_dat = $urandom;
        end
        @(negedge clk);
        disp_wea = 1'b0;
        check_rx("t3");

        // Six edges three cycles apart: fifth fills the FIFO, sixth overflows.
        for (int i = 0; i < 6; i++) begin
            do_edge($urandom, 1'b0, e);
            if (i == 4) chk("t4_level_full", fifo_level, 3'd4);
            @(negedge clk);
        end
        chk("t4_ovf_set", overflow, 1'b1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        m_ovf = 1'b0;
        chk("t4_ovf_clr", overflow, 1'b0);
        check_rx("t4");

        // Edge in the very cycle IDLE pops from a full FIFO.
        for (int i = 0; i < 5; i++) begin
            do_edge($urandom, 1'b0, e);
            @(negedge clk);
        end
        n = free_cyc;
        while (cyc < n - 1) @(negedge clk);
        do_edge($urandom, 1'b0, e);
        chk("t5_edge_cycle", e, n);
        chk("t5_level", fifo_level, 3'd4);
        chk("t5_ovf", overflow, 1'b0);
        check_rx("t5");

        // Reset in the middle of byte 2 data bits.
        do_edge($urandom, 1'b0, e);
        do_edge($urandom, 1'b0, e);
        do_edge($urandom, 1'b0, e);
        wait_start(s);
        while (cyc < s + 2 * FRAME + 5 * CPB - 10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t6_tx_async", tx, 1'b1);
        chk("t6_level", fifo_level, 3'd0);
        chk("t6_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        chk("t6_tx_hold", tx, 1'b1);
        while (exp_q.size() > 2) void'(exp_q.pop_back());
        mq.delete();
        free_cyc = 0;
        m_ovf = 1'b0;
        rst = 1'b1;
        check_rx("t6_partial");
        do_edge(32'hA5A5A5A5, 1'b0, e);
        check_rx("t6_clean");

        // Random words and gaps, occasional clear coinciding with an edge.
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 150)) @(negedge clk);
            do_edge($urandom, ($urandom_range(0, 3) == 0), e);
        end
        check_rx("rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
